// File: rtl/wb_copy_pkg.sv
// Shared types and constants for the Wishbone word-copy master.
package wb_copy_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RGAP,
    WR,
    WGAP,
    DONE
  } state_t;

  localparam int unsigned WORD_STRIDE = 4;
  localparam logic [3:0]  SEL_FULL    = 4'hF;

endpackage

// File: rtl/wb_copy_master.sv
// Wishbone classic master that copies len_i 32-bit words from src_i to dst_i,
// one read then one write per word, with an idle bus cycle after each access.
module wb_copy_master
  import wb_copy_pkg::*;
#(
  parameter int unsigned dw = 32,
  parameter int unsigned aw = 32,
  parameter int unsigned lw = 16
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          start_i,
  input  logic [aw-1:0] src_i,
  input  logic [aw-1:0] dst_i,
  input  logic [lw-1:0] len_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [aw-1:0] wb_adr_o,
  output logic [dw-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  input  logic [dw-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i
);

  state_t        state;
  logic [aw-1:0] src_q;
  logic [aw-1:0] dst_q;
  logic [aw-1:0] src_nxt_c;
  logic [aw-1:0] dst_nxt_c;
  logic [lw-1:0] cnt_q;
  logic [dw-1:0] data_q;
  logic          bus_err_c;
  logic          bus_ack_c;

  // Slave responses only count while a cycle is open; err wins over ack.
  assign bus_err_c = wb_cyc_o & wb_err_i;
  assign bus_ack_c = wb_cyc_o & wb_ack_i & ~wb_err_i;

  assign src_nxt_c = src_q + aw'(WORD_STRIDE);
  assign dst_nxt_c = dst_q + aw'(WORD_STRIDE);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state    <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      err_o    <= 1'b0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_sel_o <= '0;
      wb_we_o  <= 1'b0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            src_q  <= src_i;
            dst_q  <= dst_i;
            cnt_q  <= len_i;
            err_o  <= 1'b0;
            busy_o <= 1'b1;
            if (len_i == '0) begin
              state <= DONE;
            end else begin
              state    <= RD;
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
              wb_we_o  <= 1'b0;
              wb_sel_o <= SEL_FULL;
              wb_adr_o <= src_i;
            end
          end
        end

        RD: begin
          if (bus_err_c) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            err_o    <= 1'b1;
            state    <= DONE;
          end else if (bus_ack_c) begin
            data_q   <= wb_dat_i;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            state    <= RGAP;
          end
        end

        RGAP: begin
          state    <= WR;
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
          wb_we_o  <= 1'b1;
          wb_sel_o <= SEL_FULL;
          wb_adr_o <= dst_q;
          wb_dat_o <= data_q;
        end

        WR: begin
          if (bus_err_c) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            err_o    <= 1'b1;
            state    <= DONE;
          end else if (bus_ack_c) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            state    <= WGAP;
          end
        end

        WGAP: begin
          src_q <= src_nxt_c;
          dst_q <= dst_nxt_c;
          cnt_q <= cnt_q - lw'(1);
          if (cnt_q == lw'(1)) begin
            state <= DONE;
          end else begin
            state    <= RD;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= 1'b0;
            wb_sel_o <= SEL_FULL;
            wb_adr_o <= src_nxt_c;
          end
        end

        DONE: begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_copy_master.sv
// Randomized bench for wb_copy_master against a word-level copy model and a
// 256-word Wishbone RAM slave with optional wait states, ack hold and error injection.
module tb_wb_copy_master;

  localparam int unsigned DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] src;
  logic [31:0] dst;
  logic [15:0] len;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] adr;
  logic [31:0] dat_o;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [31:0] dat_i;
  logic        ack;
  logic        bus_err;

  wb_copy_master #(.dw(32), .aw(32), .lw(16)) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .start_i  (start),
    .src_i    (src),
    .dst_i    (dst),
    .len_i    (len),
    .busy_o   (busy),
    .done_o   (done),
    .err_o    (err),
    .wb_adr_o (adr),
    .wb_dat_o (dat_o),
    .wb_sel_o (sel),
    .wb_we_o  (we),
    .wb_cyc_o (cyc),
    .wb_stb_o (stb),
    .wb_dat_i (dat_i),
    .wb_ack_i (ack),
    .wb_err_i (bus_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic        sync;
  int          lat;
  bit          hold_ack;
  int          err_at;
  int          rd_seen;
  int          wait_cnt;

  int cycle = 0;
  int n_rd = 0;
  int n_wr = 0;
  int n_errs = 0;
  int cyc_cnt = 0;
  int n_bad_err = 0;
  bit prev_err = 1'b0;

  logic err_at_start;
  logic busy_at_start;

  // RAM slave: registered ack after lat wait cycles; may hold ack while cyc stays high.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack      <= 1'b0;
      bus_err  <= 1'b0;
      wait_cnt <= 0;
      rd_seen  <= 0;
    end else begin
      ack     <= 1'b0;
      bus_err <= 1'b0;
      if (sync) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= ref_mem[i];
      end else if (cyc && stb && !ack && !bus_err) begin
        if (wait_cnt < lat) begin
          wait_cnt <= wait_cnt + 1;
        end else begin
          wait_cnt <= 0;
          if (!we && rd_seen == err_at) begin
            bus_err <= 1'b1;
          end else begin
            ack <= 1'b1;
            if (we) mem[adr[9:2]] <= dat_o;
            else    dat_i <= mem[adr[9:2]];
          end
          if (!we) rd_seen <= rd_seen + 1;
        end
      end else if (hold_ack && ack && cyc) begin
        ack <= 1'b1;
      end
    end
  end

  // Bus monitor: completed accesses counted at the edge the master sees them.
  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (cyc) cyc_cnt <= cyc_cnt + 1;
    if (cyc && stb && ack && !bus_err && !we) n_rd <= n_rd + 1;
    if (cyc && stb && ack && !bus_err && we)  n_wr <= n_wr + 1;
    if (cyc && bus_err) n_errs <= n_errs + 1;
  end

  always @(negedge clk) begin
    if (prev_err && cyc) n_bad_err <= n_bad_err + 1;
    prev_err <= cyc && bus_err;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  function automatic int mem_diff();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  task automatic ref_copy(input logic [31:0] s, input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      int unsigned si = (s >> 2) + 32'(i);
      int unsigned di = (d >> 2) + 32'(i);
      ref_mem[di % DEPTH] = ref_mem[si % DEPTH];
    end
  endtask

  task automatic load_mem();
    @(negedge clk);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = $urandom;
  endtask

  // Issue one copy and wait (bounded) for done; lc = cycles from start to done.
  task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                     input int poke, output int lc);
    int t0;
    bit ok;
    @(negedge clk);
    src = s; dst = d; len = l; start = 1'b1;
    t0 = cycle;
    @(negedge clk);
    start = 1'b0;
    src = $urandom; dst = $urandom; len = 16'($urandom);
    err_at_start  = err;
    busy_at_start = busy;
    ok = 1'b0;
    lc = -1;
    for (int i = 0; i < 3000 && !ok; i++) begin
      if (done) begin
        ok = 1'b1;
        lc = cycle - t0;
      end else begin
        if (i == poke) begin
          start = 1'b1; src = s + 32'h80; dst = d + 32'h40; len = l + 16'd1;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
    check("done_seen", 64'(ok), 64'd1);
    if (ok) begin
      check("busy_at_done", 64'(busy), 64'd0);
      @(negedge clk);
      check("done_width", 64'(done), 64'd0);
    end
  endtask

  initial begin
    int lc;
    int a0, c0, w0, e0;
    bit found;
    logic [31:0] s, d;
    logic [15:0] l;

    rst_n = 1'b0; start = 1'b0; src = '0; dst = '0; len = '0;
    sync = 1'b0; lat = 0; hold_ack = 1'b0; err_at = -1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_cyc", 64'(cyc), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_adr", 64'(adr), 64'd0);
    check("rst_dat", 64'(dat_o), 64'd0);
    check("rst_sel", 64'(sel), 64'd0);
    rst_n = 1'b1;

    // Directed four-word copy of 1,2,3,4 from 0x00 to 0x40
    fill_random();
    for (int i = 0; i < 4; i++) ref_mem[i] = 32'(i + 1);
    load_mem();
    a0 = n_rd + n_wr;
    run(32'h0, 32'h40, 16'd4, -1, lc);
    ref_copy(32'h0, 32'h40, 4);
    check("basic_busy", 64'(busy_at_start), 64'd1);
    check("basic_latency", 64'(lc), 64'd26);
    check("basic_w0", 64'(mem[16]), 64'd1);
    check("basic_w3", 64'(mem[19]), 64'd4);
    check("basic_mem", 64'(mem_diff()), 64'd0);
    check("basic_err", 64'(err), 64'd0);
    check("basic_accesses", 64'(n_rd + n_wr - a0), 64'd8);

    // Zero-length copy: done two cycles after start, no bus cycle
    c0 = cyc_cnt;
    run(32'h10, 32'h80, 16'd0, -1, lc);
    check("zero_latency", 64'(lc), 64'd2);
    check("zero_no_cyc", 64'(cyc_cnt - c0), 64'd0);
    check("zero_mem", 64'(mem_diff()), 64'd0);

    // Start while busy is ignored
    fill_random();
    load_mem();
    a0 = n_rd + n_wr;
    run(32'h100, 32'h180, 16'd3, 5, lc);
    ref_copy(32'h100, 32'h180, 3);
    check("busy_latency", 64'(lc), 64'd20);
    check("busy_mem", 64'(mem_diff()), 64'd0);
    check("busy_accesses", 64'(n_rd + n_wr - a0), 64'd6);

    // Bus error on the second read of a three-word copy
    fill_random();
    load_mem();
    w0 = n_wr; e0 = n_errs;
    err_at = rd_seen + 1;
    run(32'h20, 32'h300, 16'd3, -1, lc);
    err_at = -1;
    ref_copy(32'h20, 32'h300, 1);
    check("err_writes", 64'(n_wr - w0), 64'd1);
    check("err_seen", 64'(n_errs - e0), 64'd1);
    check("err_cyc_drop", 64'(n_bad_err), 64'd0);
    check("err_sticky", 64'(err), 64'd1);
    check("err_mem", 64'(mem_diff()), 64'd0);
    run(32'h40, 32'h340, 16'd1, -1, lc);
    ref_copy(32'h40, 32'h340, 1);
    check("err_cleared_on_start", 64'(err_at_start), 64'd0);
    check("err_after_ok", 64'(err), 64'd0);
    check("err_next_mem", 64'(mem_diff()), 64'd0);

    // Slave holding ack through gap cycles
    hold_ack = 1'b1;
    fill_random();
    load_mem();
    a0 = n_rd + n_wr;
    run(32'h200, 32'h280, 16'd5, -1, lc);
    ref_copy(32'h200, 32'h280, 5);
    check("hold_accesses", 64'(n_rd + n_wr - a0), 64'd10);
    check("hold_latency", 64'(lc), 64'd32);
    check("hold_mem", 64'(mem_diff()), 64'd0);
    hold_ack = 1'b0;

    // Address wrap past the top of the address space
    run(32'hFFFF_FFF8, 32'h3C0, 16'd3, -1, lc);
    ref_copy(32'hFFFF_FFF8, 32'h3C0, 3);
    check("wrap_mem", 64'(mem_diff()), 64'd0);

    // Randomized copies with wait states and optional ack hold
    for (int t = 0; t < 8; t++) begin
      lat      = $urandom_range(0, 2);
      hold_ack = 1'($urandom_range(0, 1));
      s = 32'($urandom_range(0, 255)) << 2;
      d = 32'($urandom_range(0, 255)) << 2;
      l = 16'($urandom_range(1, 6));
      fill_random();
      load_mem();
      a0 = n_rd + n_wr;
      run(s, d, l, -1, lc);
      ref_copy(s, d, int'(l));
      check("rand_latency", 64'(lc), 64'(int'(l) * (6 + 2 * lat) + 2));
      check("rand_accesses", 64'(n_rd + n_wr - a0), 64'(2 * int'(l)));
      check("rand_mem", 64'(mem_diff()), 64'd0);
      check("rand_err", 64'(err), 64'd0);
    end
    lat = 0;
    hold_ack = 1'b0;

    // Asynchronous reset during a write of an eight-word copy
    fill_random();
    load_mem();
    @(negedge clk);
    src = 32'h100; dst = 32'h200; len = 16'd8; start = 1'b1;
    w0 = n_wr;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clk);
      if ((n_wr - w0) >= 1 && cyc && we) found = 1'b1;
    end
    check("rst_mid_found", 64'(found), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_cyc", 64'(cyc), 64'd0);
    check("rst_mid_stb", 64'(stb), 64'd0);
    check("rst_mid_we", 64'(we), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_adr", 64'(adr), 64'd0);
    check("rst_mid_dat", 64'(dat_o), 64'd0);
    check("rst_mid_sel", 64'(sel), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    fill_random();
    load_mem();
    run(32'h300, 32'h380, 16'd1, -1, lc);
    ref_copy(32'h300, 32'h380, 1);
    check("post_rst_latency", 64'(lc), 64'd8);
    check("post_rst_mem", 64'(mem_diff()), 64'd0);
    check("post_rst_err", 64'(err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
